micro_sequencer: RTL and testbench

//  Next-address sequencer for the microprogrammed control unit. Drives the control-store

---
 rtl/micro_sequencer.sv | 134 +++++++++++++
 tb/tb_micro_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Next-address sequencer for a microprogrammed control unit: drives the control-store
// address, the MIR load enable and the memory handshake, with a small return stack.
module micro_sequencer #(
   parameter int ADDR_W      = 10,
   parameter int STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [6:0]        Type_IN,
   input  logic [ADDR_W-1:0] DAdd_IN,
   input  logic              MR_IN,
   input  logic              MW_IN,
   input  logic [3:0]        FLAGS,
   input  logic [5:0]        IR_OPCODE,
   input  logic              MEM_READY,
   output logic [ADDR_W-1:0] MPC_OUT,
   output logic              MIR_nENABLE,
   output logic              MEM_REQ,
   output logic              HALTED,
   output logic              STACK_ERR
);
   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   typedef enum logic [1:0] {FETCH, EXEC, MEMWAIT, HALT} state_t;

   localparam logic [2:0] OP_NEXT = 3'b000, OP_JUMP = 3'b001, OP_CJUMP = 3'b010,
                          OP_CALL = 3'b011, OP_RET = 3'b100, OP_DISP = 3'b101,
                          OP_HALT = 3'b110;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] mpc_reg, mpc_next;
   logic [SP_W-1:0]   sp_reg, sp_next;
   logic              err_reg, err_next;
   logic              push;
   logic              update;
   logic              cond;
   logic              mem_access;
   logic [2:0]        op;
   logic [3:0]        sel;
   logic [ADDR_W-1:0] mpc_inc;
   logic [SP_W-1:0]   sp_dec;

   // Return stack contents need no reset; only SP defines which entries are valid.
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   assign op         = Type_IN[6:4];
   assign sel        = Type_IN[3:0];
   assign mem_access = MR_IN | MW_IN;
   assign mpc_inc    = mpc_reg + 1'b1;
   assign sp_dec     = sp_reg - 1'b1;

   always_comb begin
      cond = 1'b0;
      if (sel[3] == 1'b0)
         cond = FLAGS[sel[1:0]] ^ sel[2];
      else if (sel == 4'd8)
         cond = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      mpc_next   = mpc_reg;
      sp_next    = sp_reg;
      err_next   = err_reg;
      push       = 1'b0;
      update     = 1'b0;
      case (state_reg)
         FETCH:   state_next = EXEC;
         EXEC:    if (mem_access && !MEM_READY) state_next = MEMWAIT;
                  else update = 1'b1;
         MEMWAIT: update = MEM_READY;
         default: state_next = HALT;
      endcase

      if (update) begin
         state_next = FETCH;
         case (op)
            OP_JUMP:  mpc_next = DAdd_IN;
            OP_CJUMP: mpc_next = cond ? DAdd_IN : mpc_inc;
            OP_CALL: begin
               if (sp_reg == SP_FULL) begin
                  err_next   = 1'b1;
                  state_next = HALT;
               end else begin
                  push     = 1'b1;
                  sp_next  = sp_reg + 1'b1;
                  mpc_next = DAdd_IN;
               end
            end
            OP_RET: begin
               if (sp_reg == '0) begin
                  err_next   = 1'b1;
                  state_next = HALT;
               end else begin
                  sp_next  = sp_dec;
                  mpc_next = stack_mem[sp_dec[IDX_W-1:0]];
               end
            end
            OP_DISP:  mpc_next = {DAdd_IN[ADDR_W-1:6], IR_OPCODE};
            OP_HALT:  state_next = HALT;
            default:  mpc_next = mpc_inc;   // NEXT and the reserved op
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg <= FETCH;
         mpc_reg   <= RESET_ADDR;
         sp_reg    <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         mpc_reg   <= mpc_next;
         sp_reg    <= sp_next;
         err_reg   <= err_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         stack_mem[sp_reg[IDX_W-1:0]] <= mpc_inc;
   end

   assign MPC_OUT     = mpc_reg;
   assign MIR_nENABLE = (state_reg != FETCH);
   assign MEM_REQ     = ((state_reg == EXEC) || (state_reg == MEMWAIT)) && mem_access;
   assign HALTED      = (state_reg == HALT);
   assign STACK_ERR   = err_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed plus randomized bench for micro_sequencer, checked against a
// per-microinstruction reference model with a queue-based return stack.
module tb_micro_sequencer;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [6:0] Type_IN = '0;
   logic [9:0] DAdd_IN = '0;
   logic       MR_IN = 1'b0, MW_IN = 1'b0;
   logic [3:0] FLAGS = '0;
   logic [5:0] IR_OPCODE = '0;
   logic       MEM_READY = 1'b1;
   logic [9:0] MPC_OUT;
   logic       MIR_nENABLE, MEM_REQ, HALTED, STACK_ERR;

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_mpc;
   int m_stack[$];
   bit m_halt, m_err;

   micro_sequencer #(.ADDR_W(10), .STACK_DEPTH(4), .RESET_ADDR(10'd0)) dut (
      .CLK(CLK), .RESET(RESET), .Type_IN(Type_IN), .DAdd_IN(DAdd_IN),
      .MR_IN(MR_IN), .MW_IN(MW_IN), .FLAGS(FLAGS), .IR_OPCODE(IR_OPCODE),
      .MEM_READY(MEM_READY), .MPC_OUT(MPC_OUT), .MIR_nENABLE(MIR_nENABLE),
      .MEM_REQ(MEM_REQ), .HALTED(HALTED), .STACK_ERR(STACK_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic model_update(input int op, input int sel, input int dadd,
                               input logic [3:0] fl, input int opc);
      bit c;
      if (sel < 4)      c = fl[sel];
      else if (sel < 8) c = !fl[sel - 4];
      else              c = (sel == 8);
      case (op)
         1: m_mpc = dadd;
         2: m_mpc = c ? dadd : (m_mpc + 1) % 1024;
         3: if (m_stack.size() == 4) begin m_err = 1; m_halt = 1; end
            else begin m_stack.push_back((m_mpc + 1) % 1024); m_mpc = dadd; end
         4: if (m_stack.size() == 0) begin m_err = 1; m_halt = 1; end
            else m_mpc = m_stack.pop_back();
         5: m_mpc = (dadd / 64) * 64 + opc;
         6: m_halt = 1;
         default: m_mpc = (m_mpc + 1) % 1024;
      endcase
   endtask

   // Asserts reset at the current time and checks outputs before any clock edge.
   task automatic do_reset();
      RESET = 1'b1;
      #1;
      chk("rst_mpc", MPC_OUT, 0);
      chk("rst_nen", MIR_nENABLE, 0);
      chk("rst_memreq", MEM_REQ, 0);
      chk("rst_halted", HALTED, 0);
      chk("rst_stkerr", STACK_ERR, 0);
      MR_IN = 0; MW_IN = 0; MEM_READY = 1;
      @(negedge CLK);
      RESET = 1'b0;
      m_mpc = 0; m_stack.delete(); m_halt = 0; m_err = 0;
   endtask

   // Called at a negedge with the DUT in FETCH; runs one whole microinstruction.
   task automatic run_instr(input int op, input int sel, input int dadd, input bit mr,
                            input bit mw, input logic [3:0] fl, input int opc, input int wait_n);
      int w;
      w = (mr | mw) ? wait_n : 0;
      chk("fetch_mpc", MPC_OUT, m_mpc);
      chk("fetch_nen", MIR_nENABLE, 0);
      chk("fetch_halted", HALTED, 0);
      Type_IN = 7'(op * 16 + sel); DAdd_IN = 10'(dadd); MR_IN = mr; MW_IN = mw;
      FLAGS = fl; IR_OPCODE = 6'(opc);
      MEM_READY = (mr | mw) ? (w == 0) : 1'($urandom);
      @(negedge CLK);
      chk("exec_nen", MIR_nENABLE, 1);
      chk("exec_memreq", MEM_REQ, mr | mw);
      chk("exec_mpc", MPC_OUT, m_mpc);
      for (int i = 0; i < w; i++) begin
         @(negedge CLK);
         chk("wait_memreq", MEM_REQ, 1);
         chk("wait_mpc", MPC_OUT, m_mpc);
         chk("wait_nen", MIR_nENABLE, 1);
         FLAGS = 4'($urandom);
         MEM_READY = (i == w - 1);
      end
      model_update(op, sel, dadd, FLAGS, opc);
      @(negedge CLK);
      chk("upd_mpc", MPC_OUT, m_mpc);
      chk("upd_halted", HALTED, m_halt);
      chk("upd_nen", MIR_nENABLE, m_halt);
      chk("upd_stkerr", STACK_ERR, m_err);
      $display("instr op=%0d sel=%0d dadd=0x%0h mem=%0d wait=%0d -> mpc=0x%0h halt=%0d",
               op, sel, dadd, mr | mw, w, MPC_OUT, HALTED);
   endtask

   task automatic check_halt();
      repeat (2) begin
         @(negedge CLK);
         chk("halt_halted", HALTED, 1);
         chk("halt_mpc", MPC_OUT, m_mpc);
         chk("halt_nen", MIR_nENABLE, 1);
         chk("halt_memreq", MEM_REQ, 0);
         chk("halt_stkerr", STACK_ERR, m_err);
      end
   endtask

   initial begin
      int op, sel, wn;
      bit mr, mw;
      @(negedge CLK);
      do_reset();

      // sequential NEXT words
      repeat (3) run_instr(0, 0, 0, 0, 0, 4'h0, 0, 0);
      chk("seq_mpc3", MPC_OUT, 3);

      // conditional jumps
      run_instr(2, 0, 'h200, 0, 0, 4'b0001, 0, 0);
      run_instr(2, 0, 'h200, 0, 0, 4'b0000, 0, 0);
      chk("cjump_fall", MPC_OUT, 'h201);
      run_instr(2, 8, 'h200, 0, 0, 4'b0000, 0, 0);

      // call / return, then overflow the stack
      run_instr(1, 0, 5, 0, 0, 4'h0, 0, 0);
      run_instr(3, 0, 'h100, 0, 0, 4'h0, 0, 0);
      chk("call_target", MPC_OUT, 'h100);
      run_instr(4, 0, 0, 0, 0, 4'h0, 0, 0);
      chk("ret_target", MPC_OUT, 6);
      for (int i = 0; i < 5; i++) run_instr(3, 0, 'h40 + i, 0, 0, 4'h0, 0, 0);
      chk("ovf_err", STACK_ERR, 1);
      check_halt();
      do_reset();                       // reset while halted

      // memory wait of three cycles
      run_instr(0, 0, 0, 1, 0, 4'h0, 0, 3);
      chk("mem_adv", MPC_OUT, 1);

      // dispatch and address wrap
      run_instr(5, 0, 'h3C0, 0, 0, 4'h0, 'h15, 0);
      chk("dispatch", MPC_OUT, 'h3D5);
      run_instr(1, 0, 'h3FF, 0, 0, 4'h0, 0, 0);
      run_instr(0, 0, 0, 0, 0, 4'h0, 0, 0);
      chk("wrap", MPC_OUT, 0);

      // reset while waiting on memory
      Type_IN = 7'h00; MW_IN = 1; MEM_READY = 0;
      @(negedge CLK);
      @(negedge CLK);
      chk("memwait_req", MEM_REQ, 1);
      chk("memwait_nen", MIR_nENABLE, 1);
      do_reset();

      // randomized microprograms
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 7);
         if (op == 6 && $urandom_range(0, 3) != 0) op = 0;
         if (op == 4 && $urandom_range(0, 1) != 0) op = 3;
         sel = $urandom_range(0, 15);
         mr = ($urandom_range(0, 3) == 0);
         mw = ($urandom_range(0, 3) == 0);
         wn = $urandom_range(0, 3);
         run_instr(op, sel, $urandom_range(0, 1023), mr, mw, 4'($urandom),
                   $urandom_range(0, 63), wn);
         if (m_halt) begin
            check_halt();
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
